// File: rtl/mult_sequencer.sv
// mult_sequencer
//   Multi-cycle MULT/MULTU unit for the MIPS pipeline. It owns the HI/LO
//   architectural registers. A multiply runs WIDTH radix-2 shift-add
//   iterations on the operand magnitudes, then applies the sign in one
//   fixup cycle. While a multiply is in flight, any decode-stage HI/LO
//   access or new multiply raises a combinational stall.
//
// Ports
//   clk         rising-edge clock
//   reset       synchronous, active-high reset
//   start_mult  decode holds MULT/MULTU
//   mult_sign   1 = MULT (signed), 0 = MULTU; sampled with start_mult
//   src_a/src_b forwarded rs/rt operands; sampled with start_mult
//   read_hilo   decode holds MFHI/MFLO
//   write_hi/lo decode holds MTHI/MTLO
//   wdata       MTHI/MTLO data
//   hi/lo       architectural HI/LO (registered)
//   busy        registered, high whenever a multiply is in flight
//   done        registered one-cycle pulse after a multiply writes HI/LO
//   stall       combinational pipeline freeze for PC and IF/ID
module mult_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_mult,
  input  logic             mult_sign,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             read_hilo,
  input  logic             write_hi,
  input  logic             write_lo,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             stall
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t               state;
  state_t               next_state;
  logic [CNT_W-1:0]     count;
  logic [2*WIDTH-1:0]   acc;
  logic [WIDTH-1:0]     mcand;
  logic [WIDTH-1:0]     mplier;
  logic                 neg;

  logic                 busy_nxt;
  logic                 done_nxt;
  logic                 accept;
  logic                 reg_write_ok;
  logic [WIDTH:0]       upper_sum;
  logic [2*WIDTH-1:0]   acc_step;

  // Magnitude of a signed operand; the most negative value maps to itself,
  // which is its correct magnitude when read as unsigned.
  function automatic logic [WIDTH-1:0] magnitude(
    input logic signed [WIDTH-1:0] v,
    input logic                    is_signed
  );
    logic [WIDTH-1:0] u;
    u = v;
    if (is_signed && v[WIDTH-1])
      return (~u) + WIDTH'(1);
    return u;
  endfunction

  // Two's-complement negation of the full 2W-bit product when requested.
  function automatic logic [2*WIDTH-1:0] sign_fix(
    input logic [2*WIDTH-1:0] p,
    input logic               negate
  );
    if (negate)
      return (~p) + (2*WIDTH)'(1);
    return p;
  endfunction

  // One shift-add iteration: the upper half gains the multiplicand (with
  // carry kept in the extra bit), then the whole accumulator shifts right.
  always_comb begin
    upper_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (mplier[0] ? {1'b0, mcand} : '0);
    acc_step  = {upper_sum, acc[WIDTH-1:1]};
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start_mult) next_state = BUSY;
      BUSY:    if (count == CNT_W'(WIDTH - 1)) next_state = FIX;
      FIX:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output / control decode. stall uses only registered busy and decode
  // inputs, so there is no path from HI/LO into the stall logic.
  always_comb begin
    stall        = busy & (start_mult | read_hilo | write_hi | write_lo);
    busy_nxt     = (next_state != IDLE);
    done_nxt     = (state == FIX);
    accept       = (state == IDLE) & start_mult;
    reg_write_ok = (state == IDLE) & ~start_mult;
  end

  // Datapath and architectural registers
  always_ff @(posedge clk) begin
    if (reset) begin
      hi     <= '0;
      lo     <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      acc    <= '0;
      count  <= '0;
      mcand  <= '0;
      mplier <= '0;
      neg    <= 1'b0;
    end else begin
      busy <= busy_nxt;
      done <= done_nxt;
      if (accept) begin
        neg    <= mult_sign & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
        mcand  <= magnitude($signed(src_a), mult_sign);
        mplier <= magnitude($signed(src_b), mult_sign);
        acc    <= '0;
        count  <= '0;
      end
      // A coincident MULT wins over MTHI/MTLO; the writes are dropped.
      if (reg_write_ok) begin
        if (write_hi) hi <= wdata;
        if (write_lo) lo <= wdata;
      end
      if (state == BUSY) begin
        acc    <= acc_step;
        mplier <= mplier >> 1;
        count  <= count + CNT_W'(1);
      end
      if (state == FIX)
        {hi, lo} <= sign_fix(acc, neg);
    end
  end

endmodule

// File: tb/tb_mult_sequencer.sv
module tb_mult_sequencer;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          start_mult;
  logic          mult_sign;
  logic [W-1:0]  src_a;
  logic [W-1:0]  src_b;
  logic          read_hilo;
  logic          write_hi;
  logic          write_lo;
  logic [W-1:0]  wdata;
  logic [W-1:0]  hi;
  logic [W-1:0]  lo;
  logic          busy;
  logic          done;
  logic          stall;

  int            checks = 0;
  int            errors = 0;
  logic [63:0]   exp_q[$];
  logic [31:0]   arch_hi = '0;
  logic [31:0]   arch_lo = '0;
  logic [63:0]   mon_e;

  always #5 clk = ~clk;

  mult_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start_mult(start_mult), .mult_sign(mult_sign),
    .src_a(src_a), .src_b(src_b), .read_hilo(read_hilo), .write_hi(write_hi),
    .write_lo(write_lo), .wdata(wdata), .hi(hi), .lo(lo), .busy(busy),
    .done(done), .stall(stall)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Reference: full-precision product from plain integer arithmetic.
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint      sa, sb;
    logic [63:0] ua, ub;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    ua = {32'b0, a};
    ub = {32'b0, b};
    return ua * ub;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Monitor: pops an expected product on every done pulse; while busy,
  // HI/LO must hold their last architectural values.
  always @(posedge clk) begin
    #1;
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL done_without_request: done=1 with empty queue");
      end else begin
        mon_e = exp_q.pop_front();
        check("product", {hi, lo}, mon_e);
        arch_hi = mon_e[63:32];
        arch_lo = mon_e[31:0];
      end
    end else if (busy === 1'b1) begin
      check("hilo_hold", {hi, lo}, {arch_hi, arch_lo});
    end
  end

  // Follows one multiply from E0+1 to the cycle after E33, optionally
  // presenting a decode request (1 MFHI, 2 MTLO, 3 second MULTU from k=5).
  task automatic track(input int req, input logic [63:0] e, input logic [31:0] a2,
                       input logic [31:0] b2, input logic [31:0] wv);
    int k    = 0;
    int bcnt = 0;
    bit seen = 0;
    while (k < 40 && !seen) begin
      case (req)
        1: read_hilo = 1'b1;
        2: begin write_lo = 1'b1; wdata = wv; end
        3: if (k >= 5) begin start_mult = 1'b1; mult_sign = 1'b0; src_a = a2; src_b = b2; end
        default: ;
      endcase
      #1;
      if (req == 1 || req == 2 || (req == 3 && k >= 5))
        check("stall", {63'b0, stall}, {63'b0, (k < 33)});
      if (done === 1'b1) begin
        seen = 1;
        if (req == 1) check("read_after_mult", {hi, lo}, e);
      end else begin
        if (busy === 1'b1) bcnt++;
        @(posedge clk); #1;
        k++;
      end
    end
    check("done_seen", {63'b0, seen}, 64'd1);
    check("busy_cycles", 64'(bcnt), 64'd33);
    if (req == 1) read_hilo = 1'b0;
    if (req == 2) begin
      @(posedge clk); #1;
      write_lo = 1'b0;
      check("mtlo_after_busy", {hi, lo}, {e[63:32], wv});
      arch_lo = wv;
    end
  endtask

  task automatic mult_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input int req, input logic [31:0] a2, input logic [31:0] b2,
                         input logic [31:0] wv, input bit wr_too);
    logic [63:0] e;
    e = model(a, b, s);
    start_mult = 1'b1; mult_sign = s; src_a = a; src_b = b;
    if (wr_too) begin write_hi = 1'b1; write_lo = 1'b1; wdata = wv; end
    #1;
    check("stall_on_accept", {63'b0, stall}, 64'd0);
    exp_q.push_back(e);
    @(posedge clk); #1;
    start_mult = 1'b0; write_hi = 1'b0; write_lo = 1'b0;
    track(req, e, a2, b2, wv);
    if (req == 3) begin
      exp_q.push_back(model(a2, b2, 1'b0));
      @(posedge clk); #1;
      start_mult = 1'b0;
      check("second_accepted", {63'b0, busy}, 64'd1);
      track(0, model(a2, b2, 1'b0), '0, '0, '0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dn;
    reset = 1'b1; start_mult = 1'b0; mult_sign = 1'b0; src_a = '0; src_b = '0;
    read_hilo = 1'b0; write_hi = 1'b0; write_lo = 1'b0; wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check("reset_hilo", {hi, lo}, 64'd0);
    check("reset_busy_done", {62'b0, busy, done}, 64'd0);
    read_hilo = 1'b1; #1;
    check("idle_read_no_stall", {63'b0, stall}, 64'd0);
    read_hilo = 1'b0;

    // MTLO in IDLE, then MTHI+MTLO together
    @(posedge clk); #1;
    write_lo = 1'b1; wdata = 32'h1234_5678; #1;
    check("idle_mtlo_no_stall", {63'b0, stall}, 64'd0);
    @(posedge clk); #1;
    write_lo = 1'b0;
    check("idle_mtlo", {hi, lo}, {arch_hi, 32'h1234_5678});
    arch_lo = 32'h1234_5678;
    write_hi = 1'b1; write_lo = 1'b1; wdata = 32'hA5A5_0F0F;
    @(posedge clk); #1;
    write_hi = 1'b0; write_lo = 1'b0;
    check("idle_mthi_mtlo", {hi, lo}, {32'hA5A5_0F0F, 32'hA5A5_0F0F});
    arch_hi = 32'hA5A5_0F0F; arch_lo = 32'hA5A5_0F0F;

    // Directed products
    mult_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, '0, '0, '0, 1'b0);
    mult_op(32'hFFFF_FFFD, 32'd5,         1'b1, 0, '0, '0, '0, 1'b0);
    mult_op(32'h8000_0000, 32'h8000_0000, 1'b1, 0, '0, '0, '0, 1'b0);
    mult_op(32'h8000_0000, 32'd1,         1'b1, 0, '0, '0, '0, 1'b0);
    // Stall scenarios
    mult_op(32'd7, 32'd6, 1'b0, 1, '0, '0, '0, 1'b0);
    mult_op(32'd9, 32'hFFFF_FFF0, 1'b1, 3, 32'd2, 32'd3, '0, 1'b0);
    mult_op(32'd11, 32'd13, 1'b0, 2, '0, '0, 32'h1234_5678, 1'b0);
    // MULT coinciding with MTHI/MTLO: writes dropped
    mult_op(32'hDEAD_BEEF, 32'h0000_0100, 1'b0, 0, '0, '0, 32'h5555_AAAA, 1'b1);

    // Randomized products and requests
    for (int i = 0; i < 20; i++) begin
      mult_op(pick(), pick(), 1'($urandom_range(0, 1)), $urandom_range(0, 3),
              $urandom, $urandom, $urandom, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk); #1;
      end
    end

    // Reset in the middle of a multiply
    @(posedge clk); #1;
    start_mult = 1'b1; mult_sign = 1'b0; src_a = 32'd123; src_b = 32'd456;
    @(posedge clk); #1;
    start_mult = 1'b0;
    repeat (11) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    arch_hi = '0; arch_lo = '0;
    check("midreset_busy_done", {62'b0, busy, done}, 64'd0);
    check("midreset_hilo", {hi, lo}, 64'd0);
    dn = 0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) dn++;
      @(posedge clk); #1;
    end
    check("midreset_no_done", 64'(dn), 64'd0);
    mult_op(32'd4, 32'd4, 1'b0, 0, '0, '0, '0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
